// File: rtl/ps2_mouse_pkg.sv
// Shared definitions for the PS/2 mouse decoder: FSM encoding, protocol bytes, byte0 layout.
// No logic of its own; imported by the decoder and its accumulator.
// Constants only, no flow control.
package ps2_mouse_pkg;

  // Decoder FSM: power-up handshake, enable-streaming handshake, packet byte slots, dead end
  typedef enum logic [3:0] {
    WAIT_BAT = 4'd0,
    WAIT_ID  = 4'd1,
    SEND_F4  = 4'd2,
    WAIT_ACK = 4'd3,
    B0       = 4'd4,
    B1       = 4'd5,
    B2       = 4'd6,
    B3       = 4'd7,
    FAIL     = 4'd8
  } ps2_state_t;

  // Host command and device responses
  localparam logic [7:0] CMD_ENABLE_STREAM = 8'hF4;
  localparam logic [7:0] RSP_ACK           = 8'hFA;
  localparam logic [7:0] RSP_RESEND        = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK        = 8'hAA;
  localparam logic [7:0] RSP_DEV_ID        = 8'h00;

  // Bit positions inside the first packet byte
  localparam int B0_BTN_LSB   = 0;
  localparam int B0_BTN_MSB   = 2;
  localparam int B0_SYNC_BIT  = 3;
  localparam int B0_XSIGN_BIT = 4;
  localparam int B0_YSIGN_BIT = 5;
  localparam int B0_XOVF_BIT  = 6;
  localparam int B0_YOVF_BIT  = 7;

  // Sizes the shared timeout counter to the longest of the three limits
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Joins a sign bit from byte0 with its 8-bit magnitude byte into a 9-bit two's complement delta
  function automatic logic [8:0] ps2_delta(input logic sign, input logic [7:0] mag);
    return {sign, mag};
  endfunction

endpackage

// File: rtl/ps2_sat_accum.sv
// Saturating screen position: val <= clamp(val - delta, 0, MAX) on each enable.
// Latency: one clock from i_en to o_val.
// No backpressure; every enable is applied.
module ps2_sat_accum
  import ps2_mouse_pkg::*;
#(
  parameter int W   = 10,
  parameter int MAX = 479
) (
  input  logic         clk_25MHz,
  input  logic         reset,
  input  logic         i_en,
  input  logic [8:0]   i_delta,
  output logic [W-1:0] o_val
);

  // Two extra bits hold both the sign of the difference and a result above 2^W-1
  localparam int SW = W + 2;

  logic [W-1:0]          r_val;
  logic signed [SW-1:0]  w_cur;
  logic signed [SW-1:0]  w_del;
  logic signed [SW-1:0]  w_diff;
  logic [W-1:0]          w_next;

  assign w_cur  = $signed({2'b00, r_val});
  assign w_del  = SW'($signed(i_delta));
  assign w_diff = w_cur - w_del;

  // Clamp the signed difference into [0, MAX]
  always_comb begin
    w_next = r_val;
    if (w_diff < 0) begin
      w_next = '0;
    end else if (w_diff > SW'(MAX)) begin
      w_next = W'(MAX);
    end else begin
      w_next = w_diff[W-1:0];
    end
  end

  // Position register, starts mid-screen
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      r_val <= W'(MAX / 2);
    end else if (i_en) begin
      r_val <= w_next;
    end
  end

  assign o_val = r_val;

endmodule

// File: rtl/ps2_mouse_decoder.sv
// PS/2 mouse bring-up (BAT/ID, enable streaming with retries) and movement packet decoder.
// Latency: pkt_valid one clock after the final byte's rx_valid; y_pos one clock after pkt_valid.
// No backpressure on rx; the F4 command waits for tx_busy low before tx_write is pulsed.
module ps2_mouse_decoder
  import ps2_mouse_pkg::*;
#(
  parameter int PKT_BYTES  = 3,
  parameter int POS_W      = 10,
  parameter int POS_MAX    = 479,
  parameter int RETRY_MAX  = 3,
  parameter int ACK_TO_CYC = 250000,
  parameter int PKT_TO_CYC = 50000,
  parameter int BAT_TO_CYC = 12500000
) (
  input  logic             clk_25MHz,
  input  logic             reset,
  input  logic [7:0]       rx_byte,
  input  logic             rx_valid,
  input  logic             rx_err,
  output logic [7:0]       tx_byte,
  output logic             tx_write,
  input  logic             tx_busy,
  input  logic             tx_err,
  output logic             ready,
  output logic             init_fail,
  output logic             sync_err,
  output logic             pkt_valid,
  output logic [2:0]       buttons,
  output logic [8:0]       dx,
  output logic [8:0]       dy,
  output logic [3:0]       wheel,
  output logic [1:0]       ovf,
  output logic [POS_W-1:0] y_pos
);

  localparam bit WHEEL_EN = (PKT_BYTES == 4);
  localparam int TO_MAX   = max3(ACK_TO_CYC, PKT_TO_CYC, BAT_TO_CYC);
  localparam int TIMER_W  = $clog2(TO_MAX + 1);
  localparam int ATT_W    = (RETRY_MAX > 1) ? $clog2(RETRY_MAX + 1) : 1;

  ps2_state_t         r_state;
  ps2_state_t         w_state_nxt;
  logic [TIMER_W-1:0] r_timer;
  logic [ATT_W-1:0]   r_attempt;

  logic [7:0] r_b0;
  logic [7:0] r_b1;
  logic [7:0] r_b2;

  logic [7:0] r_tx_byte;
  logic       r_tx_write;
  logic       r_sync_err;
  logic       r_pkt_valid;
  logic [2:0] r_buttons;
  logic [8:0] r_dx;
  logic [8:0] r_dy;
  logic [3:0] r_wheel;
  logic [1:0] r_ovf;

  logic       w_accept;
  logic       w_timeout;
  logic       w_last_try;
  logic       w_tx_fire;
  logic       w_retry;
  logic       w_sync_err;
  logic       w_pkt_done;
  logic       w_cap_b0;
  logic       w_cap_b1;
  logic       w_cap_b2;
  logic [7:0] w_dy_mag;
  logic [3:0] w_wheel;
  logic       w_acc_en;
  logic       w_unused_sync;

  // A byte carrying a parity/framing error is never accepted, even with rx_valid
  assign w_accept   = rx_valid && !rx_err;
  assign w_last_try = (r_attempt == ATT_W'(RETRY_MAX - 1));

  // Select the limit that applies to the current state; states without a limit never expire
  always_comb begin
    w_timeout = 1'b0;
    case (r_state)
      WAIT_BAT, WAIT_ID: w_timeout = (r_timer == TIMER_W'(BAT_TO_CYC - 1));
      WAIT_ACK:          w_timeout = (r_timer == TIMER_W'(ACK_TO_CYC - 1));
      B1, B2, B3:        w_timeout = (r_timer == TIMER_W'(PKT_TO_CYC - 1));
      default:           w_timeout = 1'b0;
    endcase
  end

  // State register
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      r_state <= WAIT_BAT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    w_state_nxt = r_state;
    w_tx_fire   = 1'b0;
    w_retry     = 1'b0;
    w_sync_err  = 1'b0;
    w_pkt_done  = 1'b0;
    w_cap_b0    = 1'b0;
    w_cap_b1    = 1'b0;
    w_cap_b2    = 1'b0;
    case (r_state)
      WAIT_BAT: begin
        if (w_accept && rx_byte == RSP_BAT_OK) begin
          w_state_nxt = WAIT_ID;
        end else if (w_timeout) begin
          // No BAT seen: the mouse was already powered before we came out of reset
          w_state_nxt = SEND_F4;
        end
      end
      WAIT_ID: begin
        if ((w_accept && rx_byte == RSP_DEV_ID) || w_timeout) begin
          w_state_nxt = SEND_F4;
        end
      end
      SEND_F4: begin
        if (!tx_busy) begin
          w_tx_fire   = 1'b1;
          w_state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (w_accept && rx_byte == RSP_ACK) begin
          w_state_nxt = B0;
        end else if (tx_err || rx_err || rx_valid || w_timeout) begin
          // Resend (0xFE), garbage, errors and silence all count as a failed attempt
          if (w_last_try) begin
            w_state_nxt = FAIL;
          end else begin
            w_retry     = 1'b1;
            w_state_nxt = SEND_F4;
          end
        end
      end
      B0: begin
        if (w_accept) begin
          if (rx_byte[B0_SYNC_BIT]) begin
            w_cap_b0    = 1'b1;
            w_state_nxt = B1;
          end else begin
            w_sync_err = 1'b1;
          end
        end
      end
      B1: begin
        if (rx_err || (!rx_valid && w_timeout)) begin
          w_sync_err  = 1'b1;
          w_state_nxt = B0;
        end else if (rx_valid) begin
          w_cap_b1    = 1'b1;
          w_state_nxt = B2;
        end
      end
      B2: begin
        if (rx_err || (!rx_valid && w_timeout)) begin
          w_sync_err  = 1'b1;
          w_state_nxt = B0;
        end else if (rx_valid) begin
          if (WHEEL_EN) begin
            w_cap_b2    = 1'b1;
            w_state_nxt = B3;
          end else begin
            w_pkt_done  = 1'b1;
            w_state_nxt = B0;
          end
        end
      end
      B3: begin
        if (rx_err || (!rx_valid && w_timeout)) begin
          w_sync_err  = 1'b1;
          w_state_nxt = B0;
        end else if (rx_valid) begin
          w_pkt_done  = 1'b1;
          w_state_nxt = B0;
        end
      end
      FAIL: begin
        w_state_nxt = FAIL;
      end
      default: begin
        w_state_nxt = WAIT_BAT;
      end
    endcase
  end

  // One timer serves every state; it restarts on any state change or accepted byte and saturates
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_state_nxt != r_state || w_accept) begin
      r_timer <= '0;
    end else if (r_timer != {TIMER_W{1'b1}}) begin
      r_timer <= r_timer + 1'b1;
    end
  end

  // Count failed enable attempts
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      r_attempt <= '0;
    end else if (w_retry) begin
      r_attempt <= r_attempt + 1'b1;
    end
  end

  // The last byte is taken straight from rx_byte so the fields land the cycle after it arrives
  assign w_dy_mag = WHEEL_EN ? r_b2 : rx_byte;
  assign w_wheel  = WHEEL_EN ? rx_byte[3:0] : 4'h0;

  // Packet byte capture, decoded fields and output strobes
  always_ff @(posedge clk_25MHz or posedge reset) begin
    if (reset) begin
      r_b0        <= 8'h00;
      r_b1        <= 8'h00;
      r_b2        <= 8'h00;
      r_tx_byte   <= 8'h00;
      r_tx_write  <= 1'b0;
      r_sync_err  <= 1'b0;
      r_pkt_valid <= 1'b0;
      r_buttons   <= 3'b000;
      r_dx        <= 9'h000;
      r_dy        <= 9'h000;
      r_wheel     <= 4'h0;
      r_ovf       <= 2'b00;
    end else begin
      r_tx_write  <= w_tx_fire;
      r_sync_err  <= w_sync_err;
      r_pkt_valid <= w_pkt_done;
      if (w_tx_fire) begin
        r_tx_byte <= CMD_ENABLE_STREAM;
      end
      if (w_cap_b0) begin
        r_b0 <= rx_byte;
      end
      if (w_cap_b1) begin
        r_b1 <= rx_byte;
      end
      if (w_cap_b2) begin
        r_b2 <= rx_byte;
      end
      if (w_pkt_done) begin
        r_buttons <= r_b0[B0_BTN_MSB:B0_BTN_LSB];
        r_dx      <= ps2_delta(r_b0[B0_XSIGN_BIT], r_b1);
        r_dy      <= ps2_delta(r_b0[B0_YSIGN_BIT], w_dy_mag);
        r_wheel   <= w_wheel;
        r_ovf     <= {r_b0[B0_YOVF_BIT], r_b0[B0_XOVF_BIT]};
      end
    end
  end

  // Sync bit is only checked on arrival, the stored copy is never needed
  assign w_unused_sync = r_b0[B0_SYNC_BIT];

  // A Y overflow makes the delta meaningless, so the position is left alone
  assign w_acc_en = r_pkt_valid && !r_ovf[1];

  ps2_sat_accum #(
    .W   (POS_W),
    .MAX (POS_MAX)
  ) u_y_accum (
    .clk_25MHz (clk_25MHz),
    .reset     (reset),
    .i_en      (w_acc_en),
    .i_delta   (r_dy),
    .o_val     (y_pos)
  );

  assign tx_byte   = r_tx_byte;
  assign tx_write  = r_tx_write;
  assign ready     = (r_state inside {B0, B1, B2, B3});
  assign init_fail = (r_state == FAIL);
  assign sync_err  = r_sync_err;
  assign pkt_valid = r_pkt_valid;
  assign buttons   = r_buttons;
  assign dx        = r_dx;
  assign dy        = r_dy;
  assign wheel     = r_wheel;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_ps2_mouse_decoder.sv
// Bench for ps2_mouse_decoder: one 3-byte and one 4-byte instance, scoreboarded packets.
// Expected packets are queued as bytes are driven and popped on pkt_valid.
// Transmitter is modelled by tx_busy/tx_err levels driven from the stimulus.
module tb_ps2_mouse_decoder;
  import ps2_mouse_pkg::*;

  localparam int POS_MAX = 479;
  localparam int PKT_TO  = 50000;

  typedef struct packed {
    logic [2:0] btn;
    logic [8:0] dx;
    logic [8:0] dy;
    logic [3:0] wh;
    logic [1:0] ovf;
  } pkt_t;

  logic clk_25MHz = 1'b0;
  always #20 clk_25MHz = ~clk_25MHz;

  logic       reset;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  logic       tx_busy;
  logic       tx_err;
  logic       sel4;
  logic       rxv3, rxv4, rxe3, rxe4;

  assign rxv3 = rx_valid & ~sel4;
  assign rxv4 = rx_valid & sel4;
  assign rxe3 = rx_err & ~sel4;
  assign rxe4 = rx_err & sel4;

  logic [7:0] tx_byte3, tx_byte4;
  logic       tx_write3, tx_write4, ready3, ready4, init_fail3, init_fail4;
  logic       sync_err3, sync_err4, pkt_valid3, pkt_valid4;
  logic [2:0] buttons3, buttons4;
  logic [8:0] dx3, dx4, dy3, dy4;
  logic [3:0] wheel3, wheel4;
  logic [1:0] ovf3, ovf4;
  logic [9:0] y_pos3, y_pos4;

  ps2_mouse_decoder dut3 (
    .clk_25MHz(clk_25MHz), .reset(reset), .rx_byte(rx_byte), .rx_valid(rxv3), .rx_err(rxe3),
    .tx_byte(tx_byte3), .tx_write(tx_write3), .tx_busy(tx_busy), .tx_err(tx_err),
    .ready(ready3), .init_fail(init_fail3), .sync_err(sync_err3), .pkt_valid(pkt_valid3),
    .buttons(buttons3), .dx(dx3), .dy(dy3), .wheel(wheel3), .ovf(ovf3), .y_pos(y_pos3)
  );

  ps2_mouse_decoder #(.PKT_BYTES(4)) dut4 (
    .clk_25MHz(clk_25MHz), .reset(reset), .rx_byte(rx_byte), .rx_valid(rxv4), .rx_err(rxe4),
    .tx_byte(tx_byte4), .tx_write(tx_write4), .tx_busy(tx_busy), .tx_err(tx_err),
    .ready(ready4), .init_fail(init_fail4), .sync_err(sync_err4), .pkt_valid(pkt_valid4),
    .buttons(buttons4), .dx(dx4), .dy(dy4), .wheel(wheel4), .ovf(ovf4), .y_pos(y_pos4)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_tx3   = 0;
  int   n_tx4   = 0;
  int   n_sync3 = 0;
  int   exp_y   = POS_MAX / 2;
  pkt_t q3[$];
  pkt_t q4[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cmp_pkt(input string tag, input pkt_t e, input logic [2:0] b, input logic [8:0] x,
                         input logic [8:0] y, input logic [3:0] w, input logic [1:0] o);
    check({tag, "_buttons"}, 32'(b), 32'(e.btn));
    check({tag, "_dx"},      32'(x), 32'(e.dx));
    check({tag, "_dy"},      32'(y), 32'(e.dy));
    check({tag, "_wheel"},   32'(w), 32'(e.wh));
    check({tag, "_ovf"},     32'(o), 32'(e.ovf));
  endtask

  // Monitor for the 3-byte instance
  always @(negedge clk_25MHz) begin
    pkt_t e;
    if (!reset) begin
      if (tx_write3) begin
        n_tx3 = n_tx3 + 1;
        check("tx_byte3", 32'(tx_byte3), 32'(8'hF4));
      end
      if (sync_err3) n_sync3 = n_sync3 + 1;
      if (pkt_valid3) begin
        if (q3.size() == 0) check("pkt3_unexpected", 32'(pkt_valid3), 32'(0));
        else begin
          e = q3.pop_front();
          cmp_pkt("pkt3", e, buttons3, dx3, dy3, wheel3, ovf3);
        end
      end
    end
  end

  // Monitor for the 4-byte instance
  always @(negedge clk_25MHz) begin
    pkt_t e;
    if (!reset) begin
      if (tx_write4) begin
        n_tx4 = n_tx4 + 1;
        check("tx_byte4", 32'(tx_byte4), 32'(8'hF4));
      end
      if (pkt_valid4) begin
        if (q4.size() == 0) check("pkt4_unexpected", 32'(pkt_valid4), 32'(0));
        else begin
          e = q4.pop_front();
          cmp_pkt("pkt4", e, buttons4, dx4, dy4, wheel4, ovf4);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_25MHz);
  endtask

  function automatic int cur_tx();
    return sel4 ? n_tx4 : n_tx3;
  endfunction

  function automatic logic [9:0] cur_y();
    return sel4 ? y_pos4 : y_pos3;
  endfunction

  task automatic do_reset();
    @(negedge clk_25MHz);
    reset = 1'b1; rx_valid = 1'b0; rx_err = 1'b0; tx_busy = 1'b0; tx_err = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(1);
    exp_y = POS_MAX / 2;
    q3.delete();
    q4.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_25MHz);
    rx_byte = b; rx_valid = 1'b1;
    @(negedge clk_25MHz);
    rx_valid = 1'b0;
    tick(3);
  endtask

  task automatic send_err_byte(input logic [7:0] b);
    @(negedge clk_25MHz);
    rx_byte = b; rx_valid = 1'b1; rx_err = 1'b1;
    @(negedge clk_25MHz);
    rx_valid = 1'b0; rx_err = 1'b0;
    tick(3);
  endtask

  task automatic wait_tx(input int n);
    int cyc = 0;
    while (cur_tx() < n && cyc < 200) begin
      tick(1);
      cyc++;
    end
    check("tx_pulse_seen", 32'(cur_tx()), 32'(n));
  endtask

  task automatic bring_up();
    int base = cur_tx();
    send_byte(8'hAA);
    send_byte(8'h00);
    wait_tx(base + 1);
    send_byte(8'hFA);
    check("ready_up", 32'(sel4 ? ready4 : ready3), 32'(1));
  endtask

  // Expected fields straight from the packet layout; y model is a plain integer clamp
  task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    pkt_t e;
    int   d;
    e.btn = b0[2:0];
    e.dx  = {b0[4], b1};
    e.dy  = {b0[5], b2};
    e.wh  = sel4 ? b3[3:0] : 4'h0;
    e.ovf = {b0[7], b0[6]};
    if (!b0[7]) begin
      d = $signed(e.dy);
      exp_y = exp_y - d;
      if (exp_y < 0) exp_y = 0;
      if (exp_y > POS_MAX) exp_y = POS_MAX;
    end
    if (sel4) q4.push_back(e); else q3.push_back(e);
    send_byte(b0);
    send_byte(b1);
    send_byte(b2);
    if (sel4) send_byte(b3);
  endtask

  task automatic drain();
    int cyc = 0;
    while ((q3.size() + q4.size()) != 0 && cyc < 50) begin
      tick(1);
      cyc++;
    end
    check("pkt_drained", 32'(q3.size() + q4.size()), 32'(0));
    tick(2);
    check("y_pos", 32'(cur_y()), 32'(exp_y));
  endtask

  initial begin
    int base;
    int cyc;
    logic [9:0] y_snap;
    sel4 = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0; rx_err = 1'b0;
    tx_busy = 1'b0; tx_err = 1'b0; reset = 1'b1;
    tick(3);

    // Reset values
    check("rst_ready",     32'(ready3), 32'(0));
    check("rst_init_fail", 32'(init_fail3), 32'(0));
    check("rst_tx_write",  32'(tx_write3), 32'(0));
    check("rst_tx_byte",   32'(tx_byte3), 32'(0));
    check("rst_strobes",   32'({sync_err3, pkt_valid3}), 32'(0));
    check("rst_fields",    32'({buttons3, dx3, dy3, wheel3, ovf3}), 32'(0));
    check("rst_y_pos",     32'(y_pos3), 32'(239));
    check("rst_y_pos4",    32'(y_pos4), 32'(239));
    check("rst_state",     32'(dut3.r_state), 32'(WAIT_BAT));
    reset = 1'b0;
    tick(1);

    // Bring-up: stray bytes ignored, F4 held off by a busy transmitter, single tx pulse
    base = n_tx3;
    send_byte(8'h55);
    send_byte(8'h00);
    check("bat_ignores_other", 32'(dut3.r_state), 32'(WAIT_BAT));
    tx_busy = 1'b1;
    send_byte(8'hAA);
    send_byte(8'h00);
    tick(10);
    check("busy_holds_tx", 32'(n_tx3 - base), 32'(0));
    check("busy_state", 32'(dut3.r_state), 32'(SEND_F4));
    tx_busy = 1'b0;
    wait_tx(base + 1);
    send_byte(8'hFA);
    tick(2);
    check("ready_after_ack", 32'(ready3), 32'(1));
    check("single_tx", 32'(n_tx3 - base), 32'(1));

    // Large negative dy clamps at the bottom edge
    send_pkt(8'h28, 8'h05, 8'h0A, 8'h00);
    drain();
    check("dy_m246", 32'($signed(dy3)), 32'(-246));
    check("y_clamp_hi", 32'(y_pos3), 32'(479));

    // Missing sync bit, then a left-button packet from a fresh start
    do_reset();
    bring_up();
    base = n_sync3;
    send_byte(8'h01);
    tick(2);
    check("sync_bit_err", 32'(n_sync3 - base), 32'(1));
    check("sync_state_b0", 32'(dut3.r_state), 32'(B0));
    send_pkt(8'h09, 8'h00, 8'h14, 8'h00);
    drain();
    check("y_219", 32'(y_pos3), 32'(219));
    check("buttons_left", 32'(buttons3), 32'(1));

    // Y overflow leaves the position unchanged
    send_pkt(8'h88, 8'h00, 8'h50, 8'h00);
    drain();

    // rx_err wins over a simultaneous rx_valid mid-packet
    base = n_sync3;
    send_byte(8'h08);
    send_err_byte(8'h00);
    tick(2);
    check("rx_err_sync", 32'(n_sync3 - base), 32'(1));
    check("rx_err_state", 32'(dut3.r_state), 32'(B0));
    send_pkt(8'h08, 8'h01, 8'h02, 8'h00);
    drain();
    send_pkt(8'h08, 8'h00, 8'hFF, 8'h00);
    drain();
    check("y_clamp_lo", 32'(y_pos3), 32'(0));

    // Inter-byte gap timeout
    base = n_sync3;
    y_snap = y_pos3;
    send_byte(8'h08);
    send_byte(8'h00);
    cyc = 0;
    while (n_sync3 == base && cyc < PKT_TO + 100) begin
      tick(1);
      cyc++;
    end
    check("gap_sync", 32'(n_sync3 - base), 32'(1));
    check("gap_window", 32'(cyc >= PKT_TO - 10 && cyc <= PKT_TO + 2), 32'(1));
    check("gap_state_b0", 32'(dut3.r_state), 32'(B0));
    tick(2);
    check("gap_y_kept", 32'(y_pos3), 32'(y_snap));
    send_pkt(8'h18, 8'hFF, 8'h00, 8'h00);
    drain();

    // Retries exhausted
    do_reset();
    base = n_tx3;
    send_byte(8'hAA);
    send_byte(8'h00);
    for (int i = 0; i < 3; i++) begin
      wait_tx(base + i + 1);
      send_byte(8'hFE);
    end
    tick(5);
    check("retry_tx_count", 32'(n_tx3 - base), 32'(3));
    check("retry_init_fail", 32'(init_fail3), 32'(1));
    check("retry_state", 32'(dut3.r_state), 32'(FAIL));
    check("retry_not_ready", 32'(ready3), 32'(0));
    send_byte(8'hFA);
    tick(5);
    check("fail_sticky", 32'(init_fail3), 32'(1));
    check("fail_no_more_tx", 32'(n_tx3 - base), 32'(3));

    // Wheel packets on the 4-byte instance
    do_reset();
    sel4 = 1'b1;
    bring_up();
    send_pkt(8'h08, 8'h00, 8'h00, 8'h0F);
    drain();
    check("wheel_m1", 32'($signed(wheel4)), 32'(-1));
    send_pkt(8'h0D, 8'h03, 8'hFD, 8'h01);
    drain();
    sel4 = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_mouse_decoder.md
PS2_MOUSE_DECODER -- requirements
Module: ps2_mouse_decoder

Interface
REQ-001 SHALL have parameter PKT_BYTES, default 3, packet length 3 (standard) or 4 (wheel).
REQ-002 SHALL have parameter POS_W, default 10, width of y_pos.
REQ-003 SHALL have parameter POS_MAX, default 479, upper clamp of y_pos.
REQ-004 SHALL have parameter RETRY_MAX, default 3, F4 send attempts before failure.
REQ-005 SHALL have parameter ACK_TO_CYC, default 250000, ACK wait limit in clocks (10 ms).
REQ-006 SHALL have parameter PKT_TO_CYC, default 50000, inter-byte gap limit in a packet (2 ms).
REQ-007 SHALL have parameter BAT_TO_CYC, default 12500000, BAT/ID wait limit (0.5 s).
REQ-008 SHALL have port clk_25MHz  in  1  clock.
REQ-009 SHALL have port reset  in  1  reset, asynchronous, active-high.
REQ-010 SHALL have port rx_byte  in  8  received data byte from PS/2 receiver.
REQ-011 SHALL have port rx_valid  in  1  one-cycle strobe, rx_byte valid.
REQ-012 SHALL have port rx_err  in  1  one-cycle strobe, parity/framing error.
REQ-013 SHALL have port tx_byte  out  8  command byte to PS/2 transmitter.
REQ-014 SHALL have port tx_write  out  1  one-cycle strobe, start transmission.
REQ-015 SHALL have port tx_busy  in  1  transmitter busy.
REQ-016 SHALL have port tx_err  in  1  one-cycle strobe, transmission failed.
REQ-017 SHALL have port ready  out  1  streaming mode active.
REQ-018 SHALL have port init_fail  out  1  sticky, retries exhausted.
REQ-019 SHALL have port sync_err  out  1  one-cycle strobe, packet discarded.
REQ-020 SHALL have port pkt_valid  out  1  one-cycle strobe, new packet fields.
REQ-021 SHALL have port buttons  out  3  {middle,right,left} from byte0[2:0].
REQ-022 SHALL have port dx  out  9  signed X delta {byte0[4],byte1}.
REQ-023 SHALL have port dy  out  9  signed Y delta {byte0[5],byte2}.
REQ-024 SHALL have port wheel  out  4  signed byte3[3:0]; 0 when PKT_BYTES=3.
REQ-025 SHALL have port ovf  out  2  {byte0[7],byte0[6]} = {Y,X} overflow.
REQ-026 SHALL have port y_pos  out  POS_W  saturating screen Y position.

Function
REQ-027 SHALL implement states WAIT_BAT, WAIT_ID, SEND_F4, WAIT_ACK, B0, B1, B2, B3, FAIL.
REQ-028 SHALL go WAIT_BAT->WAIT_ID on byte 0xAA, WAIT_ID->SEND_F4 on byte 0x00; other bytes ignored; BAT_TO_CYC expiry in either state -> SEND_F4 (mouse already powered).
REQ-029 SHALL, in SEND_F4, hold until tx_busy=0, then pulse tx_write one cycle with tx_byte=0xF4 and enter WAIT_ACK.
REQ-030 SHALL, in WAIT_ACK: byte 0xFA -> B0, ready=1; tx_err, rx_err, any other byte (incl. 0xFE) or ACK_TO_CYC expiry -> attempt count+1, back to SEND_F4; at count=RETRY_MAX -> FAIL, init_fail=1.
REQ-031 SHALL stay in FAIL until reset.
REQ-032 SHALL, in B0, accept byte only if bit3=1 (advance to B1), else sync_err pulse and stay B0.
REQ-033 SHALL advance B1->B2, then B2->B0 (PKT_BYTES=3) or B2->B3->B0 (PKT_BYTES=4), one state per rx_valid.
REQ-034 SHALL, in B1..B3, on rx_err or inter-byte gap of PKT_TO_CYC clocks, pulse sync_err and return to B0 without pkt_valid.
REQ-035 SHALL give rx_err priority over a simultaneous rx_valid; the byte is discarded.
REQ-036 SHALL pulse pkt_valid the cycle after the final byte's rx_valid, updating buttons/dx/dy/wheel/ovf that same cycle; fields held until the next pkt_valid.
REQ-037 SHALL, on pkt_valid with ovf[1]=0, set y_pos = clamp(y_pos - dy, 0, POS_MAX), computed in POS_W+2-bit signed; ovf[1]=1 leaves y_pos unchanged.
REQ-038 SHALL use one shared timer, cleared on every state change and every accepted byte.

Reset
REQ-039 SHALL, on reset, enter WAIT_BAT immediately; ready, init_fail, sync_err, pkt_valid, tx_write, buttons, dx, dy, wheel, ovf = 0; tx_byte = 0x00; attempt count and timer = 0.
REQ-040 SHALL reset y_pos to POS_MAX/2 (integer divide, 239 by default); reset mid-packet discards partial bytes.

Structure
REQ-041 SHALL place state encoding, command/response constants (0xF4, 0xFA, 0xFE, 0xAA, 0x00) and byte0 bit positions in shared package ps2_mouse_pkg.
REQ-042 SHALL instantiate sub-module ps2_sat_accum for the clamped y_pos update.

Verification
REQ-043 SHALL cover: rx 0xAA, 0x00, then 0xFA after F4 -> exactly one tx_write with tx_byte=0xF4, ready=1.
REQ-044 SHALL cover: three 0xFE replies, RETRY_MAX=3 -> three tx_write pulses, init_fail=1, state FAIL.
REQ-045 SHALL cover: ready, rx 0x28, 0x05, 0x0A -> pkt_valid, dx=5, dy=-246, buttons=0, y_pos 239->479 (clamped).
REQ-046 SHALL cover: ready, rx 0x01 (bit3=0) -> sync_err, no pkt_valid; then 0x09, 0x00, 0x14 -> pkt_valid, buttons=1, dy=20, y_pos=219.
REQ-047 SHALL cover: rx 0x08, 0x00, then no byte for 50000 clocks -> sync_err, state B0, y_pos unchanged.
REQ-048 SHALL cover: PKT_BYTES=4, rx 0x08, 0x00, 0x00, 0x0F -> pkt_valid, wheel=-1.
